// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream valid/ready with control and data
// payloads, downstream valid/ready, flush, and the occupancy/bubble observability outputs.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy, bubble_cnt
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Falling-edge pipeline stage register with valid/ready handshake and a one-entry skid
// buffer; control is zeroed into a bubble when empty, data is carried as value only.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic           Clk,
    input  logic           Rst,
    pipe_stage_skid_if.slave bus
);

    localparam logic [1:0]       ST_EMPTY = 2'd0;
    localparam logic [1:0]       ST_FULL  = 2'd1;
    localparam logic [1:0]       ST_SKID  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic              accept_s;
    logic              take_s;
    logic              load_main_in_s;
    logic              load_main_skid_s;
    logic              load_skid_s;

    // Handshakes use only registered ready/valid, so no input reaches an output combinationally.
    assign accept_s = bus.in_valid & in_ready_r;
    assign take_s   = out_valid_r & bus.out_ready;

    // Next-state and register-load selection; flush overrides every transfer.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s    = ST_FULL;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s && take_s) begin
                    load_main_in_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = ST_SKID;
                    load_skid_s = 1'b1;
                end else if (take_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_SKID: begin
                if (take_s) begin
                    state_nxt_s      = ST_FULL;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SKID;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
        if (bus.flush) begin
            state_nxt_s      = ST_EMPTY;
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, registered handshakes and control bundles; an empty stage always shows a NOP.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_SKID);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            if (state_nxt_s == ST_EMPTY) begin
                main_ctrl_r <= {CTRL_W{1'b0}};
            end else if (load_main_in_s) begin
                main_ctrl_r <= bus.in_ctrl;
            end else if (load_main_skid_s) begin
                main_ctrl_r <= skid_ctrl_r;
            end else begin
                main_ctrl_r <= main_ctrl_r;
            end
            if (load_skid_s) begin
                skid_ctrl_r <= bus.in_ctrl;
            end else if (state_nxt_s != ST_SKID) begin
                skid_ctrl_r <= {CTRL_W{1'b0}};
            end else begin
                skid_ctrl_r <= skid_ctrl_r;
            end
        end
    end

    // Data bundles only move with an entry; flush leaves them untouched.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            main_data_r <= {DATA_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_data_r <= bus.in_data;
            end else if (load_main_skid_s) begin
                main_data_r <= skid_data_r;
            end else begin
                main_data_r <= main_data_r;
            end
            if (load_skid_s) begin
                skid_data_r <= bus.in_data;
            end else begin
                skid_data_r <= skid_data_r;
            end
        end
    end

    // Saturating count of edges on which the stage presented a bubble downstream.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (!out_valid_r && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_ctrl   = main_ctrl_r;
    assign bus.out_data   = main_data_r;
    assign bus.occupancy  = state_r;
    assign bus.bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a queue model of the stage checked every cycle, directed
// literal checks for reset, streaming, skid, flush and counter saturation, then random traffic.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } entry_t;

    logic   Clk = 1'b0;
    logic   Rst;
    int     n_vec  = 0;
    int     n_miss = 0;
    bit     chk_en = 1'b0;
    entry_t q[$];
    logic [15:0] m_cnt;
    logic [31:0] m_last;
    logic [31:0] seq_r = 32'd0;

    pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(32), .CNT_W(16)) bus1 ();
    pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(32), .CNT_W(4))  bus2 ();

    pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus1)
    );
    pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Rst(Rst), .bus(bus2)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] c, input logic [31:0] d,
                         input logic ordy, input logic fl);
        bus1.in_valid  = iv;
        bus1.in_ctrl   = c;
        bus1.in_data   = d;
        bus1.out_ready = ordy;
        bus1.flush     = fl;
    endtask

    // Reference model: the stage is a FIFO of at most two entries, updated on each falling edge.
    always @(negedge Clk) begin
        bit m_rdy, m_vld;
        m_rdy = (q.size() < 2);
        m_vld = (q.size() != 0);
        if (Rst) begin
            q.delete();
            m_cnt  = 16'd0;
            m_last = 32'd0;
        end else begin
            if (!m_vld && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (bus1.flush) begin
                q.delete();
            end else begin
                if (m_vld && bus1.out_ready) void'(q.pop_front());
                if (bus1.in_valid && m_rdy) q.push_back('{c: bus1.in_ctrl, d: bus1.in_data});
            end
            if (q.size() != 0) m_last = q[0].d;
        end
    end

    // Compare every DUT output against the model on the rising edge, mid-cycle.
    always @(posedge Clk) begin
        if (chk_en) begin
            chk("m_out_valid", bus1.out_valid, (q.size() != 0));
            chk("m_in_ready",  bus1.in_ready,  (q.size() < 2));
            chk("m_out_ctrl",  bus1.out_ctrl,  (q.size() != 0) ? q[0].c : 8'h00);
            chk("m_out_data",  bus1.out_data,  m_last);
            chk("m_occupancy", bus1.occupancy, q.size());
            chk("m_bubble",    bus1.bubble_cnt, m_cnt);
        end
    end

    initial begin
        bus2.in_valid  = 1'b0;
        bus2.in_ctrl   = 8'h00;
        bus2.in_data   = 32'd0;
        bus2.out_ready = 1'b0;
        bus2.flush     = 1'b0;
        drive(1'b0, 8'h00, 32'd0, 1'b1, 1'b0);
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_out_valid", bus1.out_valid, 1'b0);
        chk("rst_in_ready",  bus1.in_ready, 1'b1);
        chk("rst_out_ctrl",  bus1.out_ctrl, 8'h00);
        chk("rst_out_data",  bus1.out_data, 32'd0);
        chk("rst_occupancy", bus1.occupancy, 2'd0);
        chk("rst_bubble",    bus1.bubble_cnt, 16'd0);

        for (int i = 0; i < 5; i++) tick();
        chk("idle5_bubble", bus1.bubble_cnt, 16'd5);
        chk("idle5_bubble_sat", bus2.bubble_cnt, 4'd5);
        for (int i = 0; i < 9; i++) tick();
        chk("idle14_bubble_sat", bus2.bubble_cnt, 4'd14);
        for (int i = 0; i < 6; i++) tick();
        chk("idle20_bubble_sat", bus2.bubble_cnt, 4'd15);
        chk("idle20_bubble", bus1.bubble_cnt, 16'd20);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'hA5, 32'(i), 1'b1, 1'b0);
            tick();
            chk("stream_data", bus1.out_data, 32'(i));
            chk("stream_ctrl", bus1.out_ctrl, 8'hA5);
            chk("stream_occ",  bus1.occupancy, 2'd1);
        end
        drive(1'b0, 8'h00, 32'd0, 1'b1, 1'b0);
        tick();
        chk("stream_end_valid", bus1.out_valid, 1'b0);
        chk("stream_end_ctrl",  bus1.out_ctrl, 8'h00);
        chk("stream_end_data",  bus1.out_data, 32'd8);

        // Skid: back-pressure arrives with the second entry
        drive(1'b1, 8'h11, 32'h11, 1'b1, 1'b0);
        tick();
        chk("skid_first", bus1.out_data, 32'h11);
        drive(1'b1, 8'h22, 32'h22, 1'b0, 1'b0);
        tick();
        chk("skid_occ2", bus1.occupancy, 2'd2);
        chk("skid_rdy0", bus1.in_ready, 1'b0);
        chk("skid_head", bus1.out_data, 32'h11);
        drive(1'b1, 8'h33, 32'h33, 1'b0, 1'b0);
        tick();
        chk("skid_hold_occ", bus1.occupancy, 2'd2);
        chk("skid_hold_head", bus1.out_data, 32'h11);
        drive(1'b1, 8'h33, 32'h33, 1'b1, 1'b0);
        tick();
        chk("skid_drain1", bus1.out_data, 32'h22);
        chk("skid_drain1_ctrl", bus1.out_ctrl, 8'h22);
        chk("skid_drain1_rdy", bus1.in_ready, 1'b1);
        tick();
        chk("skid_drain2", bus1.out_data, 32'h33);
        chk("skid_drain2_occ", bus1.occupancy, 2'd1);
        drive(1'b0, 8'h00, 32'd0, 1'b1, 1'b0);
        tick();
        chk("skid_empty", bus1.out_valid, 1'b0);

        // Flush while holding two entries, with an entry offered on the flush edge
        drive(1'b1, 8'hFF, 32'h55, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hFF, 32'h66, 1'b0, 1'b0);
        tick();
        chk("flush_pre_occ", bus1.occupancy, 2'd2);
        drive(1'b1, 8'hFF, 32'h44, 1'b0, 1'b1);
        tick();
        chk("flush_valid", bus1.out_valid, 1'b0);
        chk("flush_ctrl",  bus1.out_ctrl, 8'h00);
        chk("flush_occ",   bus1.occupancy, 2'd0);
        chk("flush_rdy",   bus1.in_ready, 1'b1);
        chk("flush_data_kept", bus1.out_data, 32'h55);
        drive(1'b0, 8'h00, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_ghost", bus1.out_valid, 1'b0);
        end

        // Random traffic with sparse flushes; each offered word is unique
        for (int i = 0; i < 10000; i++) begin
            seq_r = seq_r + 32'd1;
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), seq_r,
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 31) == 0));
            tick();
        end
        chk("sat_final", bus2.bubble_cnt, 4'd15);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
